// File: rtl/iic_init_sequencer.sv
// Replays a table of I2C register writes to a byte-level I2C master, one entry
// per burst, with an idle gap between entries and bounded per-entry retry.
module iic_init_sequencer #(
  parameter int DEPTH      = 32,
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 1,
  parameter int GAP_CYCLES = 24000,
  parameter int MAX_RETRY  = 3,
  localparam int NB        = ADDR_BYTES + DATA_BYTES,
  localparam int WORD_W    = 8 * NB,
  localparam int IW        = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        dev_addr_i,
  input  logic [IW:0]       len_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              tbl_we_i,
  input  logic [IW-1:0]     tbl_addr_i,
  input  logic [WORD_W-1:0] tbl_wdata_i,
  output logic              stb_o,
  output logic [7:0]        a_o,
  output logic [7:0]        d_o,
  input  logic              done_i,
  input  logic              err_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [IW-1:0]     idx_o,
  output logic [3:0]        retry_o
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int BW = 3;
  localparam logic [IW:0]   DEPTH_W   = (IW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LD    = GW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] LAST_B    = BW'(NB - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  // state | meaning
  // IDLE  | waiting for start after reset
  // FETCH | reading the current entry from the table
  // SEND  | streaming entry bytes, stb_o high
  // GAP   | idle spacing before next entry or before a retry
  // DONE  | all entries sent, done_o high
  // FAIL  | retries exhausted or aborted, fail_o high
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_GAP, S_DONE, S_FAIL} state_t;

  logic [WORD_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW:0]       len_q, len_d;
  logic [6:0]        dev_q, dev_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [3:0]        retry_q, retry_d;
  logic              abort_q, abort_d;
  logic              resend_q, resend_d;

  logic [IW:0]       len_clamp;
  logic [IW:0]       idx_next;
  logic [7:0]        cur_byte;
  logic              busy;

  assign busy      = state_q inside {S_FETCH, S_SEND, S_GAP};
  assign len_clamp = (len_i > DEPTH_W) ? DEPTH_W : len_i;
  assign idx_next  = {1'b0, idx_q} + (IW+1)'(1);

  always_ff @(posedge clk_i) begin
    if (tbl_we_i && !busy) mem_q[tbl_addr_i] <= tbl_wdata_i;
  end

  // Word stays intact during SEND so a retry can restart from byte 0 without a refetch.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (bcnt_q == BW'(i)) cur_byte = word_q[8*(NB-1-i) +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    dev_d    = dev_q;
    word_d   = word_q;
    bcnt_d   = bcnt_q;
    gap_d    = gap_q;
    retry_d  = retry_q;
    abort_d  = abort_q;
    resend_d = resend_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          dev_d    = dev_addr_i;
          len_d    = len_clamp;
          idx_d    = '0;
          retry_d  = '0;
          abort_d  = 1'b0;
          resend_d = 1'b0;
          state_d  = (len_clamp == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort_i) begin
          state_d = S_FAIL;
        end else begin
          word_d  = mem_q[idx_q];
          bcnt_d  = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (abort_i) abort_d = 1'b1;
        if (done_i) begin
          if (abort_q || abort_i) begin
            state_d = S_FAIL;
          end else if (err_i) begin
            if (retry_q < RETRY_MAX) begin
              retry_d  = retry_q + 4'd1;
              resend_d = 1'b1;
              gap_d    = GAP_LD;
              state_d  = S_GAP;
            end else begin
              state_d = S_FAIL;
            end
          end else if (bcnt_q == LAST_B) begin
            gap_d   = GAP_LD;
            state_d = S_GAP;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      S_GAP: begin
        if (abort_i) begin
          state_d = S_FAIL;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (resend_q) begin
          resend_d = 1'b0;
          bcnt_d   = '0;
          state_d  = S_SEND;
        end else if (idx_next == len_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          retry_d = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      dev_q    <= '0;
      word_q   <= '0;
      bcnt_q   <= '0;
      gap_q    <= '0;
      retry_q  <= '0;
      abort_q  <= 1'b0;
      resend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      dev_q    <= dev_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      gap_q    <= gap_d;
      retry_q  <= retry_d;
      abort_q  <= abort_d;
      resend_q <= resend_d;
    end
  end

  assign stb_o   = (state_q == S_SEND);
  assign a_o     = {dev_q, 1'b0};
  assign d_o     = stb_o ? cur_byte : 8'h00;
  assign busy_o  = busy;
  assign done_o  = (state_q == S_DONE);
  assign fail_o  = (state_q == S_FAIL);
  assign idx_o   = idx_q;
  assign retry_o = retry_q;

endmodule
